rf_wr_arbiter: RTL

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_wr_fifo.sv | 76 +++++++
 rtl/rf_wr_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and arbiter state encoding for the register-file write arbiter
package rf_pkg;

  localparam int RF_DATA_W     = 16;
  localparam int RF_IDX_W      = 2;
  localparam int RF_NUM_REGS   = 2 ** RF_IDX_W;
  localparam int RF_FIFO_DEPTH = 2;

  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - per-requester write queue holding {index, data}
// Also reports which register indices have a pending entry in the queue.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int IDX_W  = RF_IDX_W,
  parameter int DEPTH  = RF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [IDX_W-1:0]      i_push_index,
  input  logic [DATA_W-1:0]     i_push_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [IDX_W-1:0]      o_head_index,
  output logic [DATA_W-1:0]     o_head_data,
  output logic [2**IDX_W-1:0]   o_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]  r_idx  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full       = (r_count == CNT_W'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_do_push    = i_push & ~o_full;
  assign w_do_pop     = i_pop & ~o_empty;
  assign o_head_index = r_idx[r_rd_ptr];
  assign o_head_data  = r_data[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_idx[r_wr_ptr]  <= i_push_index;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((i + DEPTH - int'(r_rd_ptr)) % DEPTH) < int'(r_count)) o_busy[r_idx[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - two-requester register-file write arbiter with per-requester queues
// Alternating-preference arbitration; one registered write per cycle.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int IDX_W      = RF_IDX_W,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [IDX_W-1:0]    req0_index,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [IDX_W-1:0]    req1_index,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                wr_enable,
  output logic [IDX_W-1:0]    wr_index,
  output logic [DATA_W-1:0]   wr_data,
  output logic [2**IDX_W-1:0] busy_mask
);

  localparam int NUM_REGS = 2 ** IDX_W;

  logic                w_full0, w_empty0, w_full1, w_empty1;
  logic [IDX_W-1:0]    w_head_idx0, w_head_idx1;
  logic [DATA_W-1:0]   w_head_data0, w_head_data1;
  logic [NUM_REGS-1:0] w_busy0, w_busy1;
  logic                w_grant0, w_grant1;

  arb_state_t          r_state;
  logic                r_wr_enable;
  logic [IDX_W-1:0]    r_wr_index;
  logic [DATA_W-1:0]   r_wr_data;

  // Ready is held low throughout reset even though the queues already read empty.
  assign req0_ready = rst & ~w_full0;
  assign req1_ready = rst & ~w_full1;

  rf_wr_fifo #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk          (clk),
    .rst          (rst),
    .i_push       (req0_valid & req0_ready),
    .i_push_index (req0_index),
    .i_push_data  (req0_data),
    .i_pop        (w_grant0),
    .o_full       (w_full0),
    .o_empty      (w_empty0),
    .o_head_index (w_head_idx0),
    .o_head_data  (w_head_data0),
    .o_busy       (w_busy0)
  );

  rf_wr_fifo #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk          (clk),
    .rst          (rst),
    .i_push       (req1_valid & req1_ready),
    .i_push_index (req1_index),
    .i_push_data  (req1_data),
    .i_pop        (w_grant1),
    .o_full       (w_full1),
    .o_empty      (w_empty1),
    .o_head_index (w_head_idx1),
    .o_head_data  (w_head_data1),
    .o_busy       (w_busy1)
  );

  assign w_grant0 = ~w_empty0 & (w_empty1 | (r_state == PREF0));
  assign w_grant1 = ~w_empty1 & (w_empty0 | (r_state == PREF1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= PREF0;
      r_wr_enable <= 1'b0;
      r_wr_index  <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_enable <= w_grant0 | w_grant1;
      if (w_grant0) begin
        r_wr_index <= w_head_idx0;
        r_wr_data  <= w_head_data0;
        r_state    <= PREF1;
      end else if (w_grant1) begin
        r_wr_index <= w_head_idx1;
        r_wr_data  <= w_head_data1;
        r_state    <= PREF0;
      end
    end
  end

  assign wr_enable = r_wr_enable;
  assign wr_index  = r_wr_index;
  assign wr_data   = r_wr_data;
  assign busy_mask = w_busy0 | w_busy1 |
                     (r_wr_enable ? (NUM_REGS'(1) << r_wr_index) : '0);

endmodule
